// File: rtl/integrador_desplazamiento_if.sv
// Bus bundle for the displacement integrator.
// Controls in, fixed/half-float displacement and status out.
interface integrador_desplazamiento_if;
  logic        habilitar;
  logic        limpiar;
  logic [23:0] velocidadFixed;
  logic [31:0] desplazamientof;
  logic [15:0] desplazamientoFloat;
  logic        impulso;
  logic        ocupado;
  logic        saturado;

  modport slave (
    input  habilitar,
    input  limpiar,
    input  velocidadFixed,
    output desplazamientof,
    output desplazamientoFloat,
    output impulso,
    output ocupado,
    output saturado
  );

  modport master (
    output habilitar,
    output limpiar,
    output velocidadFixed,
    input  desplazamientof,
    input  desplazamientoFloat,
    input  impulso,
    input  ocupado,
    input  saturado
  );
endinterface

// File: rtl/integrador_desplazamiento.sv
// Integrates Q16.8 velocity into a saturating Q24.8 displacement
// and converts its integer part to half-float once per sample tick.
module integrador_desplazamiento #(
  parameter int PERIODO_MUESTRA = 1000
) (
  input logic clock,
  input logic reset_n,
  integrador_desplazamiento_if.slave bus
);

  if (PERIODO_MUESTRA < 32) begin : gPeriodo
    $error("PERIODO_MUESTRA must be >= 32");
  end

  localparam int CW = $clog2(PERIODO_MUESTRA);

  typedef enum logic [1:0] {
    ESPERA,
    NORMALIZA,
    EMPAQUETA
  } estado_t;

  estado_t estado, estadoSig;

  logic [CW-1:0] cuenta;
  logic          tick;
  logic          arranque;
  logic [32:0]   suma;
  logic [31:0]   accSig;
  logic [15:0]   regDesp;
  logic [3:0]    desplaz;
  logic          esCero;
  logic          esInf;
  logic          salir;
  logic [4:0]    exponente;
  logic [15:0]   empaquetado;

  always_comb begin
    tick = cuenta == CW'(PERIODO_MUESTRA - 1);
    arranque = tick & (bus.limpiar | bus.habilitar);
    suma = {1'b0, bus.desplazamientof} +
           {9'b0, bus.velocidadFixed};
    accSig = '0;
    if (!bus.limpiar)
      accSig = suma[32] ? '1 : suma[31:0];
    salir = esCero | esInf | regDesp[15];
    exponente = 5'd30 - {1'b0, desplaz};
    empaquetado = {1'b0, exponente, regDesp[14:5]};
    if (esInf)
      empaquetado = 16'h7C00;
    else if (esCero)
      empaquetado = 16'h0000;
  end

  always_comb begin
    estadoSig = estado;
    unique case (estado)
      ESPERA:    if (arranque) estadoSig = NORMALIZA;
      NORMALIZA: if (salir) estadoSig = EMPAQUETA;
      EMPAQUETA: estadoSig = ESPERA;
      default:   estadoSig = ESPERA;
    endcase
  end

  assign bus.ocupado = estado != ESPERA;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado                  <= ESPERA;
      cuenta                  <= '0;
      regDesp                 <= '0;
      desplaz                 <= '0;
      esCero                  <= 1'b0;
      esInf                   <= 1'b0;
      bus.desplazamientof     <= '0;
      bus.desplazamientoFloat <= '0;
      bus.impulso             <= 1'b0;
      bus.saturado            <= 1'b0;
    end else begin
      estado      <= estadoSig;
      cuenta      <= tick ? '0 : cuenta + 1'b1;
      bus.impulso <= 1'b0;
      if (arranque) begin
        bus.desplazamientof <= accSig;
        if (bus.limpiar)
          bus.saturado <= 1'b0;
        else if (suma[32])
          bus.saturado <= 1'b1;
        // n = accSig[31:8]; only its low 16 bits are normalised
        regDesp <= accSig[23:8];
        desplaz <= '0;
        esCero  <= accSig[31:8] == 24'd0;
        esInf   <= |accSig[31:24];
      end else if (estado == NORMALIZA && !salir) begin
        regDesp <= {regDesp[14:0], 1'b0};
        desplaz <= desplaz + 1'b1;
      end
      if (estado == EMPAQUETA) begin
        bus.desplazamientoFloat <= empaquetado;
        bus.impulso             <= 1'b1;
      end
    end
  end

endmodule
